// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bus of the bit-serial adder.
//   in_valid/in_ready/a/b        : operand handshake (master -> adder)
//   out_valid/out_ready/sum/
//   carry_out                    : result handshake (adder -> master)
//   busy                         : adder is stepping through operand bits
//   fsm_state                    : adder state for observation (IDLE=0, SHIFT=1, HOLD=2)
// The master modport is the side that supplies operands and takes results.
// The slave modport is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;
  logic [1:0]       fsm_state;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy, fsm_state
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry_out, busy, fsm_state
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder. Adds two WIDTH-bit operands
// LSB-first, one bit per clock, with a single full-adder cell and a
// registered carry. Returns {carry_out, sum} == a + b.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : serial_adder_if.slave (operand and result handshakes, busy,
//          fsm_state for observation)
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. The producer keeps valid (and data) asserted until that
// edge; ready never depends combinationally on valid. Operands are taken
// only in IDLE; a result is offered only in HOLD and held there (sum,
// carry_out, out_valid stable) until out_ready is seen.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_if.slave       bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_bit;
  logic             last_bit;
  logic [WIDTH-1:0] res_nxt;

  // Single full-adder cell working on the current LSBs.
  assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_bit    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_bit = (cnt == CW'(WIDTH - 1));
  // New sum bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
  assign res_nxt  = {s_bit, res_sh[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last_bit)      state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          carry  <= c_bit;
          if (last_bit) begin
            // Counter parks at WIDTH-1; it is reloaded on the next acceptance.
            sum_q  <= res_nxt;
            cout_q <= c_bit;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // in_ready is masked by rst so it reads 0 while reset is held.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state == SHIFT);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder at
// WIDTH=8 and WIDTH=16. Expected results come from plain a+b arithmetic.
module tb_serial_adder;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [8:0]  exp8_q[$];
  logic [16:0] exp16_q[$];

  serial_adder_if #(.WIDTH(8))  i8 ();
  serial_adder_if #(.WIDTH(16)) i16 ();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8.slave));
  serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16.slave));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed driver (WIDTH=8) ----------------
  // Runs one operation; pulses in_valid with junk operands when the cycle
  // count after acceptance equals pulse; stalls out_ready for stall cycles.
  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                      input int stall, input int pulse,
                      output logic [7:0] s, output logic c,
                      output int lat, output int busy_cnt);
    int  guard;
    logic ok;
    guard = 0;
    while (!i8.in_ready && guard < 50) begin tick(); guard++; end
    if (guard >= 50) chk({tag, "_ready_timeout"}, i8.in_ready, 1);
    i8.in_valid  = 1'b1;
    i8.a         = ta;
    i8.b         = tb_v;
    i8.out_ready = 1'b0;
    tick();
    lat = 0;
    busy_cnt = 0;
    while (!i8.out_valid && lat < 50) begin
      if (i8.busy) busy_cnt++;
      i8.in_valid = (lat == pulse);
      i8.a = 8'hAA;
      i8.b = 8'h55;
      tick();
      lat++;
    end
    i8.in_valid = 1'b0;
    s = i8.sum;
    c = i8.carry_out;
    ok = 1'b1;
    for (int k = 0; k < stall; k++) begin
      tick();
      if (!(i8.out_valid === 1'b1 && i8.sum === s && i8.carry_out === c && i8.in_ready === 1'b0))
        ok = 1'b0;
    end
    if (stall > 0) chk({tag, "_hold_stable"}, ok, 1);
    i8.out_ready = 1'b1;
    tick();
    i8.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, i8.out_valid, 0);
    chk({tag, "_ready_back"}, i8.in_ready, 1);
    chk({tag, "_sum_kept"}, {i8.carry_out, i8.sum}, {c, s});
  endtask

  // ---------------- random drivers / monitors ----------------
  task automatic drive8(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      int guard;
      repeat ($urandom_range(0, 3)) tick();
      ra = 8'($urandom);
      rb = 8'($urandom);
      i8.in_valid = 1'b1;
      i8.a = ra;
      i8.b = rb;
      guard = 0;
      while (!i8.in_ready && guard < 200) begin tick(); guard++; end
      if (guard >= 200) begin
        chk("drv8_accept", i8.in_ready, 1);
        break;
      end
      exp8_q.push_back({1'b0, ra} + {1'b0, rb});
      tick();
      i8.in_valid = 1'b0;
    end
  endtask

  task automatic mon8(input int n);
    int got;
    int cyc;
    logic [8:0] e;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 60000) begin
      i8.out_ready = 1'($urandom_range(0, 1));
      if (i8.out_valid && i8.out_ready) begin
        if (exp8_q.size() == 0) chk("r8_extra", exp8_q.size(), 1);
        else begin
          e = exp8_q.pop_front();
          chk("r8_result", {i8.carry_out, i8.sum}, e);
        end
        got++;
      end
      tick();
      cyc++;
    end
    i8.out_ready = 1'b0;
    chk("r8_count", got, n);
    chk("r8_leftover", exp8_q.size(), 0);
  endtask

  task automatic drive16(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      int guard;
      repeat ($urandom_range(0, 3)) tick();
      ra = 16'($urandom);
      rb = 16'($urandom);
      i16.in_valid = 1'b1;
      i16.a = ra;
      i16.b = rb;
      guard = 0;
      while (!i16.in_ready && guard < 200) begin tick(); guard++; end
      if (guard >= 200) begin
        chk("drv16_accept", i16.in_ready, 1);
        break;
      end
      exp16_q.push_back({1'b0, ra} + {1'b0, rb});
      tick();
      i16.in_valid = 1'b0;
    end
  endtask

  task automatic mon16(input int n);
    int got;
    int cyc;
    logic [16:0] e;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 60000) begin
      i16.out_ready = 1'($urandom_range(0, 1));
      if (i16.out_valid && i16.out_ready) begin
        if (exp16_q.size() == 0) chk("r16_extra", exp16_q.size(), 1);
        else begin
          e = exp16_q.pop_front();
          chk("r16_result", {i16.carry_out, i16.sum}, e);
        end
        got++;
      end
      tick();
      cyc++;
    end
    i16.out_ready = 1'b0;
    chk("r16_count", got, n);
    chk("r16_leftover", exp16_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] s;
    logic       c;
    int         lat;
    int         bc;
    int         seen;

    rst = 1'b1;
    i8.in_valid = 1'b0;  i8.a = '0;  i8.b = '0;  i8.out_ready = 1'b0;
    i16.in_valid = 1'b0; i16.a = '0; i16.b = '0; i16.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", i8.in_ready, 0);
    chk("rst_out_valid", i8.out_valid, 0);
    chk("rst_busy", i8.busy, 0);
    chk("rst_result", {i8.carry_out, i8.sum}, 9'h000);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", i8.in_ready, 1);

    run8("t3c05", 8'h3C, 8'h05, 0, -1, s, c, lat, bc);
    chk("t3c05_result", {c, s}, 9'h041);
    chk("t3c05_latency", lat, 8);
    chk("t3c05_busy_cycles", bc, 8);

    run8("tff01", 8'hFF, 8'h01, 0, -1, s, c, lat, bc);
    chk("tff01_result", {c, s}, 9'h100);
    run8("tffff", 8'hFF, 8'hFF, 0, -1, s, c, lat, bc);
    chk("tffff_result", {c, s}, 9'h1FE);
    run8("t0000", 8'h00, 8'h00, 0, -1, s, c, lat, bc);
    chk("t0000_result", {c, s}, 9'h000);

    run8("bp", 8'h9A, 8'h7B, 5, -1, s, c, lat, bc);
    chk("bp_result", {c, s}, 9'h115);

    run8("ign", 8'h10, 8'h20, 0, 3, s, c, lat, bc);
    chk("ign_result", {c, s}, 9'h030);

    // Reset while bit 4 of 0x7F+0x7F is next to be processed.
    i8.in_valid = 1'b1;
    i8.a = 8'h7F;
    i8.b = 8'h7F;
    tick();
    i8.in_valid = 1'b0;
    repeat (4) tick();
    chk("abort_busy", i8.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_in_ready", i8.in_ready, 1);
    chk("abort_out_valid", i8.out_valid, 0);
    chk("abort_busy_clear", i8.busy, 0);
    seen = 0;
    repeat (12) begin
      tick();
      if (i8.out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    run8("t0102", 8'h01, 8'h02, 0, -1, s, c, lat, bc);
    chk("t0102_result", {c, s}, 9'h003);

    fork
      drive8(1000);
      mon8(1000);
      drive16(1000);
      mon16(1000);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
